// File: rtl/palette_pkg.sv
// palette_pkg: shared types and helpers for the 4bpp palette read and write paths.
//   rgb565_t        - RGB565 pixel as {r[4:0], g[5:0], b[4:0]}
//   PIXEL16/PIXEL24 - build an RGB565 value from 5/6/5 components or from RGB888
//   DEFAULT_PALETTE - reset contents of the 16-entry palette (index 0 in the low word)
//   stripe_address  - row-striped framebuffer address used by both paths
//   color_distance  - weighted L1 distance between two RGB565 colours
//   state_t         - encoder FSM states
package palette_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH_HI = 2'd1,
    SEARCH_LO = 2'd2,
    WRITE     = 2'd3
  } state_t;

  function automatic rgb565_t PIXEL16(input logic [4:0] r, input logic [5:0] g,
                                      input logic [4:0] b);
    return rgb565_t'({r, g, b});
  endfunction

  function automatic rgb565_t PIXEL24(input logic [23:0] rgb);
    return rgb565_t'({rgb[23:19], rgb[15:10], rgb[7:3]});
  endfunction

  // Black, white, red, green, blue, cyan, magenta, yellow, twice; entry 15 first.
  localparam logic [15:0][15:0] DEFAULT_PALETTE = {
    16'hFFE0, 16'hF81F, 16'h07FF, 16'h001F, 16'h07E0, 16'hF800, 16'hFFFF, 16'h0000,
    16'hFFE0, 16'hF81F, 16'h07FF, 16'h001F, 16'h07E0, 16'hF800, 16'hFFFF, 16'h0000
  };

  // The stripe thresholds are the multiples 1..7 of 16'h1FE0; each threshold
  // crossed pushes the low half of the address up by one 32-byte gap.
  function automatic logic [23:0] stripe_address(input logic [23:0] addr);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 1; i <= 7; i++) begin
      if (addr[15:0] >= 16'(i * 16'h1FE0)) begin
        k = k + 4'd1;
      end else begin
        k = k;
      end
    end
    return {addr[23:16], addr[15:0] + {7'd0, k, 5'd0}};
  endfunction

  // d = 2*|dr| + |dg| + 2*|db|; the maximum is 187 so 8 bits never overflow.
  function automatic logic [7:0] color_distance(input rgb565_t a, input rgb565_t b);
    logic [4:0] dr;
    logic [5:0] dg;
    logic [4:0] db;
    dr = (a.r > b.r) ? (a.r - b.r) : (b.r - a.r);
    dg = (a.g > b.g) ? (a.g - b.g) : (b.g - a.g);
    db = (a.b > b.b) ? (a.b - b.b) : (b.b - a.b);
    return {2'd0, dr, 1'b0} + {2'd0, dg} + {2'd0, db, 1'b0};
  endfunction

endpackage

// File: rtl/palette_nearest.sv
// palette_nearest: one step of the sequential nearest-colour search.
//   start     - this step is the first of a new search (best treated as 8'hFF)
//   step      - compare entry/entry_idx against the running best this cycle
//   pixel     - colour being searched for
//   entry     - palette entry at entry_idx
//   index     - best index including this cycle's step
//   distance  - best distance including this cycle's step
// The outputs show the result the registers will hold after this edge, so
// the caller can take the final answer during the last step.
import palette_pkg::*;

module palette_nearest (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic [15:0] pixel,
  input  logic [15:0] entry,
  input  logic [3:0]  entry_idx,
  output logic [3:0]  index,
  output logic [7:0]  distance
);

  logic [3:0] best_idx;
  logic [7:0] best_dist;
  logic [7:0] cand_dist;
  logic [3:0] base_idx;
  logic [7:0] base_dist;
  logic       take;

  // Candidate comparison; strict less-than keeps the lowest index on ties.
  always_comb begin
    cand_dist = color_distance(rgb565_t'(pixel), rgb565_t'(entry));
    base_dist = start ? 8'hFF : best_dist;
    base_idx  = start ? 4'd0  : best_idx;
    take      = step && (cand_dist < base_dist);
    if (take) begin
      index    = entry_idx;
      distance = cand_dist;
    end else begin
      index    = base_idx;
      distance = base_dist;
    end
  end

  // Running best registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_idx  <= 4'd0;
      best_dist <= 8'hFF;
    end else if (step) begin
      best_idx  <= index;
      best_dist <= distance;
    end
  end

endmodule

// File: rtl/palette_encoder.sv
// palette_encoder: packs two RGB565 pixels per slave write into one 4bpp byte.
//   clk, reset                - clock, asynchronous active-high reset
//   avs_slave_*               - pixel-pair write port (address unstriped)
//   avm_master_*              - packed byte write to framebuffer (address striped)
//   avs_palette_*             - 16-entry palette write and 1-cycle readback
// Flow: IDLE accepts a word, SEARCH_HI and SEARCH_LO each scan entries 0..15
// one per cycle, WRITE holds the master write until it is not stalled.
import palette_pkg::*;

module palette_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_slave_write,
  input  logic [23:0] avs_slave_address,
  input  logic [31:0] avs_slave_writedata,
  output logic        avs_slave_waitrequest,
  output logic        avm_master_write,
  output logic [23:0] avm_master_address,
  output logic [7:0]  avm_master_writedata,
  input  logic        avm_master_waitrequest,
  input  logic [3:0]  avs_palette_address,
  input  logic [15:0] avs_palette_writedata,
  input  logic        avs_palette_write,
  output logic [15:0] avs_palette_readdata
);

  state_t      state;
  logic [3:0]  cnt;
  logic [23:0] cap_addr;
  logic [15:0] pix_hi;
  logic [15:0] pix_lo;
  logic [3:0]  idx_hi;
  logic [15:0] palette [16];
  logic [3:0]  best_index;
  logic [7:0]  best_dist_unused;
  logic        search_start;
  logic        search_step;
  logic [15:0] search_pixel;

  assign avs_slave_waitrequest = (state != IDLE);
  assign search_step  = (state == SEARCH_HI) || (state == SEARCH_LO);
  assign search_start = (cnt == 4'd0);
  assign search_pixel = (state == SEARCH_HI) ? pix_hi : pix_lo;

  palette_nearest u_nearest (
    .clk       (clk),
    .reset     (reset),
    .start     (search_start),
    .step      (search_step),
    .pixel     (search_pixel),
    .entry     (palette[cnt]),
    .entry_idx (cnt),
    .index     (best_index),
    .distance  (best_dist_unused)
  );

  // Palette storage and registered readback (a same-cycle write reads old data).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        palette[i] <= DEFAULT_PALETTE[i];
      end
      avs_palette_readdata <= 16'h0000;
    end else begin
      if (avs_palette_write) begin
        palette[avs_palette_address] <= avs_palette_writedata;
      end
      avs_palette_readdata <= palette[avs_palette_address];
    end
  end

  // Encoder FSM with registered master outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= 4'd0;
      cap_addr             <= 24'h000000;
      pix_hi               <= 16'h0000;
      pix_lo               <= 16'h0000;
      idx_hi               <= 4'd0;
      avm_master_write     <= 1'b0;
      avm_master_address   <= 24'h000000;
      avm_master_writedata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (avs_slave_write) begin
            cap_addr <= stripe_address(avs_slave_address);
            pix_hi   <= avs_slave_writedata[31:16];
            pix_lo   <= avs_slave_writedata[15:0];
            cnt      <= 4'd0;
            state    <= SEARCH_HI;
          end
        end
        SEARCH_HI: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            idx_hi <= best_index;
            state  <= SEARCH_LO;
          end
        end
        SEARCH_LO: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            avm_master_write     <= 1'b1;
            avm_master_address   <= cap_addr;
            avm_master_writedata <= {idx_hi, best_index};
            state                <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_master_waitrequest) begin
            avm_master_write <= 1'b0;
            state            <= IDLE;
          end
        end
        default: begin
          avm_master_write <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_encoder.sv
// tb_palette_encoder: directed table, hand-written corner sequences and
// random pixel pairs checked against a behavioural nearest-colour model.
module tb_palette_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_slave_write = 1'b0;
  logic [23:0] avs_slave_address = 24'h0;
  logic [31:0] avs_slave_writedata = 32'h0;
  logic        avs_slave_waitrequest;
  logic        avm_master_write;
  logic [23:0] avm_master_address;
  logic [7:0]  avm_master_writedata;
  logic        avm_master_waitrequest = 1'b0;
  logic [3:0]  avs_palette_address = 4'h0;
  logic [15:0] avs_palette_writedata = 16'h0;
  logic        avs_palette_write = 1'b0;
  logic [15:0] avs_palette_readdata;

  int total = 0;
  int bad = 0;

  logic [15:0] pal [16];

  palette_encoder dut (
    .clk                    (clk),
    .reset                  (reset),
    .avs_slave_write        (avs_slave_write),
    .avs_slave_address      (avs_slave_address),
    .avs_slave_writedata    (avs_slave_writedata),
    .avs_slave_waitrequest  (avs_slave_waitrequest),
    .avm_master_write       (avm_master_write),
    .avm_master_address     (avm_master_address),
    .avm_master_writedata   (avm_master_writedata),
    .avm_master_waitrequest (avm_master_waitrequest),
    .avs_palette_address    (avs_palette_address),
    .avs_palette_writedata  (avs_palette_writedata),
    .avs_palette_write      (avs_palette_write),
    .avs_palette_readdata   (avs_palette_readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    logic [23:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] default_entry(input int i);
    case (i % 8)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'hF800;
      3: return 16'h07E0;
      4: return 16'h001F;
      5: return 16'h07FF;
      6: return 16'hF81F;
      default: return 16'hFFE0;
    endcase
  endfunction

  task automatic model_reset_palette();
    for (int i = 0; i < 16; i++) pal[i] = default_entry(i);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] ref_nearest(input logic [15:0] p);
    int best_d;
    logic [3:0] best_i;
    best_d = 1 << 30;
    best_i = 4'd0;
    for (int i = 0; i < 16; i++) begin
      int dd;
      dd = 2 * iabs(int'(p[15:11]) - int'(pal[i][15:11]))
         +     iabs(int'(p[10:5])  - int'(pal[i][10:5]))
         + 2 * iabs(int'(p[4:0])   - int'(pal[i][4:0]));
      if (dd < best_d) begin
        best_d = dd;
        best_i = 4'(i);
      end
    end
    return best_i;
  endfunction

  // Thresholds are k*16'h1FE0 for k=1..7, so the gap count is a capped quotient.
  function automatic logic [23:0] ref_stripe(input logic [23:0] a);
    int k;
    logic [15:0] lo;
    k = int'(a[15:0]) / 8160;
    if (k > 7) k = 7;
    lo = 16'((int'(a[15:0]) + k * 32) % 65536);
    return {a[23:16], lo};
  endfunction

  // Issue one pixel pair from an idle encoder and check the resulting byte write.
  task automatic run_pixel(input string name, input logic [23:0] a, input logic [31:0] d,
                           input logic [23:0] ea, input logic [7:0] ed);
    int n;
    chk({name, " idle"}, {31'd0, avs_slave_waitrequest}, 32'd0);
    avs_slave_write = 1'b1;
    avs_slave_address = a;
    avs_slave_writedata = d;
    tick();
    avs_slave_write = 1'b0;
    n = 1;
    chk({name, " busy"}, {31'd0, avs_slave_waitrequest}, 32'd1);
    while (!avm_master_write && n < 200) begin
      tick();
      n++;
    end
    chk({name, " latency"}, n, 33);
    chk({name, " addr"}, {8'd0, avm_master_address}, {8'd0, ea});
    chk({name, " data"}, {24'd0, avm_master_writedata}, {24'd0, ed});
    tick();
    chk({name, " done"}, {30'd0, avm_master_write, avs_slave_waitrequest}, 32'd0);
  endtask

  initial begin
    logic [23:0] ra;
    logic [31:0] rd;
    logic [23:0] held_addr;
    logic [7:0]  held_data;
    logic        stable;
    logic        seen;
    int          n;

    vecs[0] = '{24'h000010, 32'hF800_07E0, 24'h000010, 8'h23};
    vecs[1] = '{24'h001FE0, 32'hF800_07E0, 24'h002000, 8'h23};
    vecs[2] = '{24'h01DF20, 32'h0000_FFFF, 24'h01E000, 8'h01};
    vecs[3] = '{24'h001FDF, 32'h001F_07FF, 24'h001FDF, 8'h45};
    vecs[4] = '{24'h000040, 32'hF000_0000, 24'h000040, 8'h20};
    vecs[5] = '{24'h12FFFF, 32'hFFE0_F81F, 24'h1200DF, 8'h76};

    model_reset_palette();

    // Reset state, sampled while reset is still asserted.
    tick();
    tick();
    chk("reset waitrequest", {31'd0, avs_slave_waitrequest}, 32'd0);
    chk("reset mwrite", {31'd0, avm_master_write}, 32'd0);
    chk("reset maddr", {8'd0, avm_master_address}, 32'd0);
    chk("reset mdata", {24'd0, avm_master_writedata}, 32'd0);
    chk("reset readdata", {16'd0, avs_palette_readdata}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_pixel($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
                vecs[i].exp_addr, vecs[i].exp_data);
    end

    for (int i = 0; i < 12; i++) begin
      ra = 24'($urandom);
      rd = $urandom;
      run_pixel($sformatf("rand%0d", i), ra, rd, ref_stripe(ra),
                {ref_nearest(rd[31:16]), ref_nearest(rd[15:0])});
    end

    // Backpressure: stall the master for 5 cycles starting at cycle 33.
    avm_master_waitrequest = 1'b1;
    avs_slave_write = 1'b1;
    avs_slave_address = 24'h000100;
    avs_slave_writedata = 32'hF800_07E0;
    tick();
    avs_slave_write = 1'b0;
    n = 1;
    while (!avm_master_write && n < 200) begin
      tick();
      n++;
    end
    chk("stall latency", n, 33);
    held_addr = avm_master_address;
    held_data = avm_master_writedata;
    chk("stall addr", {8'd0, held_addr}, 32'h000100);
    chk("stall data", {24'd0, held_data}, 32'h23);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!avm_master_write || avm_master_address !== held_addr ||
          avm_master_writedata !== held_data || !avs_slave_waitrequest) stable = 1'b0;
    end
    tick();
    avm_master_waitrequest = 1'b0;
    if (!avm_master_write || avm_master_address !== held_addr ||
        avm_master_writedata !== held_data || !avs_slave_waitrequest) stable = 1'b0;
    chk("stall stable", {31'd0, stable}, 32'd1);
    tick();
    run_pixel("after stall", 24'h003FC0, 32'h07E0_F800, 24'h004000, 8'h32);

    // Palette: same-cycle write returns old data, then new data next cycle.
    avs_palette_address = 4'd6;
    avs_palette_writedata = 16'h0ABC;
    avs_palette_write = 1'b1;
    tick();
    avs_palette_write = 1'b0;
    pal[6] = 16'h0ABC;
    chk("pal same-cycle old", {16'd0, avs_palette_readdata}, 32'hF81F);
    tick();
    chk("pal entry6 new", {16'd0, avs_palette_readdata}, 32'h0ABC);
    avs_palette_address = 4'd5;
    avs_palette_writedata = 16'h1234;
    avs_palette_write = 1'b1;
    tick();
    avs_palette_write = 1'b0;
    pal[5] = 16'h1234;
    tick();
    chk("pal entry5 readback", {16'd0, avs_palette_readdata}, 32'h1234);
    run_pixel("pal match", 24'h000020, 32'h1234_1234, 24'h000020, 8'h55);
    for (int i = 0; i < 4; i++) begin
      ra = 24'($urandom);
      rd = $urandom;
      run_pixel($sformatf("rand pal%0d", i), ra, rd, ref_stripe(ra),
                {ref_nearest(rd[31:16]), ref_nearest(rd[15:0])});
    end

    // Reset at cycle 10 of a search: no master write and palette back to defaults.
    avs_slave_write = 1'b1;
    avs_slave_address = 24'h000200;
    avs_slave_writedata = 32'hF800_07E0;
    tick();
    avs_slave_write = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    #1;
    model_reset_palette();
    chk("midreset waitrequest", {31'd0, avs_slave_waitrequest}, 32'd0);
    chk("midreset mwrite", {31'd0, avm_master_write}, 32'd0);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (avm_master_write || avs_slave_waitrequest) seen = 1'b1;
    end
    chk("midreset no write", {31'd0, seen}, 32'd0);
    avs_palette_address = 4'd5;
    tick();
    chk("midreset entry5", {16'd0, avs_palette_readdata}, 32'h07FF);
    run_pixel("post reset", 24'h000030, 32'h1234_07FF, 24'h000030,
              {ref_nearest(16'h1234), 4'd5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/palette_encoder.md
# palette_encoder

Write-path counterpart of the 4bpp palette read path. Accepts two RGB565 pixels per 32-bit Avalon-MM slave write, maps each to the nearest palette index with a sequential 16-entry search, and packs both indices into one byte. The byte is written to framebuffer memory through an Avalon-MM master at the row-striped address. It holds its own software-writable 16-entry palette and sits between the CPU/DMA bridge and the packed 4bpp framebuffer.

## Interface
- No parameters. Widths are fixed: 24-bit addresses, RGB565 pixels, 4-bit indices.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- avs_slave_write  in  1  pixel-pair write request.
- avs_slave_address  in  24  unstriped byte address.
- avs_slave_writedata  in  32  [31:16] pixel for the high nibble, [15:0] pixel for the low nibble.
- avs_slave_waitrequest  out  1  high while busy.
- avm_master_write  out  1  packed byte write.
- avm_master_address  out  24  striped byte address.
- avm_master_writedata  out  8  {idx_hi, idx_lo}.
- avm_master_waitrequest  in  1  memory stall.
- avs_palette_address  in  4  palette entry select.
- avs_palette_writedata  in  16  RGB565 entry value.
- avs_palette_write  in  1  palette write strobe.
- avs_palette_readdata  out  16  registered entry readback.

## Operation
- **FSM states:** IDLE, SEARCH_HI, SEARCH_LO, WRITE.
  - IDLE: avs_slave_waitrequest=0. When avs_slave_write=1, capture the striped address and both pixels, then go to SEARCH_HI.
  - SEARCH_HI and SEARCH_LO: each scans entries 0..15, one per cycle, using a 4-bit counter. SEARCH_HI searches for pixel [31:16]; SEARCH_LO searches for pixel [15:0].
  - WRITE: assert avm_master_write with the captured address and packed byte. Go to IDLE in the cycle after a cycle where avm_master_waitrequest=0.
- **avs_slave_waitrequest:** equals (state != IDLE), decoded from registered state.
- **Distance metric:** d = 2*|dr| + |dg| + 2*|db|, with r and b 5-bit and g 6-bit. d is 8 bits unsigned, max 187, and cannot overflow.
- **Best-match tracking:** keep a running best index and distance. Replace the best only on strictly smaller d, so ties resolve to the lowest index. Best distance is initialised to 8'hFF at each search start.
- **Address striping:**
  - k = number of thresholds in {1FE0, 3FC0, 5FA0, 7F80, 9F60, BF40, DF20} that address[15:0] is ≥ (range 0..7).
  - striped[15:0] = address[15:0] + k*16'h20, modulo 2^16.
  - striped[23:16] = address[23:16], passed through unchanged.
- **Palette port:**
  - avs_palette_write updates the entry at the clock edge, in any state.
  - avs_palette_readdata <= palette[avs_palette_address] every cycle, giving 1-cycle read latency. A same-cycle write returns the old value.
  - The search reads live entries. Software must update the palette only while the encoder is idle; a mid-search update produces a mix of old and new entries, which is legal but undefined.
- **Reset palette:** black, white, red, green, blue, cyan, magenta, yellow, repeated once for entries 8..15.

## Timing
- Reset values: state IDLE, avs_slave_waitrequest 0, avm_master_write 0, avm_master_address 0, avm_master_writedata 0, avs_palette_readdata 0, palette set to the defaults.
- A write is accepted at cycle 0.
  - SEARCH_HI runs cycles 1–16.
  - SEARCH_LO runs cycles 17–32.
  - avm_master_write is first high at cycle 33.
  - With no stall, IDLE is reached at cycle 34, where the next write can be accepted. Throughput is one word per 34 cycles.
- Master stall: avm_master_address, avm_master_writedata and avm_master_write are held stable while avm_master_waitrequest=1. avs_slave_waitrequest stays high throughout.
- Slave writes arriving while waitrequest=1 are not accepted; the upstream master holds them.
- Reset asserted mid-operation: all outputs go to reset values immediately, with no partial master write. Captured data is discarded and the palette returns to the defaults.

## Structure
- **palette_pkg** contains:
  - the rgb565_t typedef;
  - the PIXEL16 and PIXEL24 colour functions;
  - the default 16-entry palette constant;
  - a stripe_address() function, shared with the read-path palette block;
  - a state_t enum.
- **palette_nearest** is one natural sub-module: a combinational distance unit plus the best-index/best-distance registers, with start and step inputs and index and distance outputs.
- The FSM, palette storage and Avalon ports stay in palette_encoder.

## Test plan
- **Exact match, default palette:** write 32'hF800_07E0 to 24'h000010 → avm write at cycle 33, address 24'h000010, data 8'h23.
- **Striping:**
  - address 24'h001FE0 → 24'h002000.
  - address 24'h01DF20 → 24'h01E000.
  - address 24'h001FDF → unchanged.
- **Nearest and ties:**
  - pixel 16'hF000 (r=30) → index 2.
  - 32'h0000_FFFF → 8'h01: black ties at indices 0 and 8, and the lowest index wins.
- **Backpressure:** hold avm_master_waitrequest high for 5 cycles → master outputs stable and avs_slave_waitrequest high throughout. The next write is accepted 1 cycle after the stall ends.
- **Palette update:** write entry 5 = 16'h1234, then read entry 5 → 16'h1234 one cycle later. Pixel pair 32'h1234_1234 → byte 8'h55.
- **Reset mid-search:** assert reset at cycle 10 → no master write occurs, avs_slave_waitrequest is 0, and entry 5 reads back 16'h07FF (cyan default).
